// File: rtl/codec_init_sequencer_pkg.sv
// Shared encodings for the codec init sequencer: FSM state codes, I2C direction
// constants and the default codec address.
package codec_init_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_STARTUP   = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_WAIT_BUSY = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_GAP       = 3'd5,
    ST_DONE      = 3'd6,
    ST_ERROR     = 3'd7
  } seq_state_e;

  localparam logic       MODE_READ          = 1'b0;
  localparam logic       MODE_WRITE         = 1'b1;
  localparam logic [6:0] DEFAULT_CODEC_ADDR = 7'h1A;

endpackage

// File: rtl/codec_init_rom.sv
// Codec register init table: combinational, zero latency, no flow control.
// Indices past the populated entries return zero.
module codec_init_rom (
  input  logic [3:0] idx,
  output logic [7:0] dat
);

  always_comb begin
    dat = 8'h00;
    case (idx)
      4'd0:    dat = 8'h1E;
      4'd1:    dat = 8'h97;
      4'd2:    dat = 8'h12;
      4'd3:    dat = 8'h0C;
      4'd4:    dat = 8'h0E;
      4'd5:    dat = 8'h10;
      4'd6:    dat = 8'h0A;
      4'd7:    dat = 8'h08;
      4'd8:    dat = 8'h02;
      4'd9:    dat = 8'h01;
      default: dat = 8'h00;
    endcase
  end

endmodule

// File: rtl/codec_init_sequencer.sv
// Walks the codec init table into an I2C controller, one write per entry, waiting on i2c_ready.
// Enable is issued in the ISSUE cycle that sees i2c_ready; every wait on the controller is timeout-bounded.
module codec_init_sequencer
  import codec_init_sequencer_pkg::*;
#(
  parameter logic [6:0]  PERIPH_ADDR    = DEFAULT_CODEC_ADDR,
  parameter int unsigned NUM_WRITES     = 10,
  parameter int unsigned STARTUP_CYCLES = 1000,
  parameter int unsigned GAP_CYCLES     = 100,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       i2c_ready,
  output logic       i2c_enable,
  output logic       i2c_mode,
  output logic [6:0] i2c_periph_addr,
  output logic [7:0] i2c_transmit_byte,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [3:0] seq_index,
  output logic [2:0] state
);

  localparam int unsigned WAIT_MAX = (STARTUP_CYCLES > GAP_CYCLES) ? STARTUP_CYCLES : GAP_CYCLES;
  localparam int unsigned WAIT_W   = $clog2(WAIT_MAX + 1);
  localparam int unsigned TMO_W    = $clog2(TIMEOUT_CYCLES);

  localparam logic [WAIT_W-1:0] STARTUP_LOAD = WAIT_W'(STARTUP_CYCLES);
  localparam logic [WAIT_W-1:0] GAP_LOAD     = WAIT_W'(GAP_CYCLES);
  localparam logic [TMO_W-1:0]  TMO_LAST     = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]        LAST_IDX     = 4'(NUM_WRITES - 1);

  seq_state_e        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [3:0]        idx_q, idx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              stalled;

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    tmo_d   = tmo_q;
    idx_d   = idx_q;
    done_d  = done_q;
    err_d   = err_q;
    stalled = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_d = ST_STARTUP;
          done_d  = 1'b0;
          err_d   = 1'b0;
          idx_d   = 4'd0;
          wait_d  = STARTUP_LOAD;
        end
      end
      ST_STARTUP, ST_GAP: begin
        if (wait_q <= WAIT_W'(1)) begin
          wait_d = '0;
          if (state_q == ST_STARTUP) begin
            state_d = ST_ISSUE;
          end else if (idx_q < LAST_IDX) begin
            idx_d   = idx_q + 4'd1;
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end else begin
          wait_d = wait_q - WAIT_W'(1);
        end
      end
      ST_ISSUE: begin
        if (i2c_ready) state_d = ST_WAIT_BUSY;
        else           stalled = 1'b1;
      end
      ST_WAIT_BUSY: begin
        if (!i2c_ready) state_d = ST_WAIT_DONE;
        else            stalled = 1'b1;
      end
      ST_WAIT_DONE: begin
        if (i2c_ready) begin
          state_d = ST_GAP;
          wait_d  = GAP_LOAD;
        end else begin
          stalled = 1'b1;
        end
      end
      default: ;
    endcase

    // A stalled wait state gets TIMEOUT_CYCLES cycles in total before giving up.
    if (stalled) begin
      if (tmo_q == TMO_LAST) begin
        state_d = ST_ERROR;
        err_d   = 1'b1;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end
    if (state_d != state_q) tmo_d = '0;

    busy_d = state_d inside {ST_STARTUP, ST_ISSUE, ST_WAIT_BUSY, ST_WAIT_DONE, ST_GAP};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      wait_q  <= '0;
      tmo_q   <= '0;
      idx_q   <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      tmo_q   <= tmo_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  codec_init_rom u_rom (
    .idx (idx_q),
    .dat (i2c_transmit_byte)
  );

  // Decoded from the state flop so the request lives only in ISSUE and only alongside ready.
  assign i2c_enable      = (state_q == ST_ISSUE) && i2c_ready;
  assign i2c_mode        = MODE_WRITE;
  assign i2c_periph_addr = PERIPH_ADDR;
  assign busy            = busy_q;
  assign done            = done_q;
  assign error           = err_q;
  assign seq_index       = idx_q;
  assign state           = state_q;

endmodule

// File: tb/tb_codec_init_sequencer.sv
// Directed bench for codec_init_sequencer with a small I2C controller model.
module tb_codec_init_sequencer;
  import codec_init_sequencer_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       i2c_ready = 1'b1;
  logic       i2c_enable;
  logic       i2c_mode;
  logic [6:0] i2c_periph_addr;
  logic [7:0] i2c_transmit_byte;
  logic       busy;
  logic       done;
  logic       error;
  logic [3:0] seq_index;
  logic [2:0] state;

  codec_init_sequencer #(
    .PERIPH_ADDR    (7'h1A),
    .NUM_WRITES     (3),
    .STARTUP_CYCLES (4),
    .GAP_CYCLES     (2),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .i2c_ready         (i2c_ready),
    .i2c_enable        (i2c_enable),
    .i2c_mode          (i2c_mode),
    .i2c_periph_addr   (i2c_periph_addr),
    .i2c_transmit_byte (i2c_transmit_byte),
    .busy              (busy),
    .done              (done),
    .error             (error),
    .seq_index         (seq_index),
    .state             (state)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         en_count = 0;
  logic [7:0] sent[$];
  logic [7:0] last_byte = 8'h00;
  bit         prev_en = 1'b0;
  bit         ctl_hold = 1'b0;
  bit         ctl_stuck = 1'b0;
  bit         arm = 1'b0;
  bit         mdl_rdy = 1'b1;
  int         low_left = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Controller: after each enable, ready drops for 5 cycles (unless stuck); hold forces ready low.
  always begin
    @(negedge clk);
    if (arm) begin
      mdl_rdy  = 1'b0;
      low_left = 5;
      arm      = 1'b0;
    end else if (low_left > 0) begin
      low_left--;
      if (low_left == 0) mdl_rdy = 1'b1;
    end
    i2c_ready = mdl_rdy && !ctl_hold;
    #2;
    if (i2c_enable === 1'b1) begin
      en_count++;
      sent.push_back(i2c_transmit_byte);
      last_byte = i2c_transmit_byte;
      check("en_needs_ready", 32'(i2c_ready), 32'd1);
      check("en_single_cycle", 32'(prev_en), 32'd0);
      check("en_only_in_issue", 32'(state), 32'(ST_ISSUE));
      if (!ctl_stuck) arm = 1'b1;
    end
    if (state === ST_WAIT_BUSY || state === ST_WAIT_DONE)
      check("byte_stable", 32'(i2c_transmit_byte), 32'(last_byte));
    prev_en = i2c_enable;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] st, input int budget, input string tag);
    int n = 0;
    while (state !== st && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(state), 32'(st));
  endtask

  task automatic check_bytes(input string tag);
    check({tag, "_count"}, 32'(sent.size()), 32'd3);
    if (sent.size() == 3) begin
      check({tag, "_b0"}, 32'(sent[0]), 32'h1E);
      check({tag, "_b1"}, 32'(sent[1]), 32'h97);
      check({tag, "_b2"}, 32'(sent[2]), 32'h12);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, 32'(state), 32'(ST_IDLE));
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_idx"}, 32'(seq_index), 32'd0);
    check({tag, "_enable"}, 32'(i2c_enable), 32'd0);
    check({tag, "_byte"}, 32'(i2c_transmit_byte), 32'h1E);
    check({tag, "_mode"}, 32'(i2c_mode), 32'd1);
    check({tag, "_addr"}, 32'(i2c_periph_addr), 32'h1A);
  endtask

  initial begin
    int n;
    int en0;

    repeat (3) tick();
    check_reset_outputs("rst");
    reset = 1'b1;
    repeat (2) tick();
    check("idle_no_start", 32'(state), 32'(ST_IDLE));

    // Full run: 3 entries, startup then ISSUE after 4 cycles.
    pulse_start();
    check("run1_startup", 32'(state), 32'(ST_STARTUP));
    check("run1_busy", 32'(busy), 32'd1);
    n = 0;
    while (state !== ST_ISSUE && n < 20) begin
      tick();
      n++;
    end
    check("run1_startup_len", 32'(n), 32'd4);
    wait_state(ST_DONE, 100, "run1_done_state");
    check_bytes("run1");
    check("run1_done", 32'(done), 32'd1);
    check("run1_busy_low", 32'(busy), 32'd0);
    check("run1_idx", 32'(seq_index), 32'd2);
    check("run1_byte_last", 32'(i2c_transmit_byte), 32'h12);
    check("run1_error", 32'(error), 32'd0);

    // Restart from DONE, with a start pulse landing in GAP.
    sent.delete();
    pulse_start();
    check("rerun_done_clr", 32'(done), 32'd0);
    check("rerun_state", 32'(state), 32'(ST_STARTUP));
    check("rerun_idx", 32'(seq_index), 32'd0);
    wait_state(ST_GAP, 50, "rerun_gap");
    pulse_start();
    check("gap_start_ignored", 32'(state), 32'(ST_GAP));
    check("gap_start_idx", 32'(seq_index), 32'd0);
    tick();
    check("gap_to_issue", 32'(state), 32'(ST_ISSUE));
    check("gap_idx_inc", 32'(seq_index), 32'd1);
    wait_state(ST_DONE, 100, "rerun_done_state");
    check_bytes("rerun");
    check("rerun_done", 32'(done), 32'd1);

    // Controller busy on entering ISSUE for 6 cycles.
    ctl_hold = 1'b1;
    pulse_start();
    wait_state(ST_ISSUE, 20, "hold_issue");
    en0 = en_count;
    repeat (5) tick();
    check("hold_still_issue", 32'(state), 32'(ST_ISSUE));
    check("hold_no_enable", 32'(en_count), 32'(en0));
    ctl_hold = 1'b0;
    tick();
    check("hold_release_state", 32'(state), 32'(ST_WAIT_BUSY));
    check("hold_release_en", 32'(en_count), 32'(en0 + 1));
    wait_state(ST_DONE, 100, "hold_done_state");

    // Reset during WAIT_DONE of entry 1.
    pulse_start();
    n = 0;
    while (!(state === ST_WAIT_DONE && seq_index === 4'd1) && n < 100) begin
      tick();
      n++;
    end
    check("rst_mid_state", 32'(state), 32'(ST_WAIT_DONE));
    check("rst_mid_idx", 32'(seq_index), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("rst_async");
    tick();
    tick();
    reset = 1'b1;
    en0 = en_count;
    repeat (20) tick();
    check("rst_no_resume", 32'(state), 32'(ST_IDLE));
    check("rst_no_enable", 32'(en_count), 32'(en0));

    // Controller never drops ready after enable: timeout.
    ctl_stuck = 1'b1;
    en0 = en_count;
    pulse_start();
    wait_state(ST_WAIT_BUSY, 20, "tmo_wait_busy");
    n = 0;
    while (state !== ST_ERROR && n < 30) begin
      tick();
      n++;
    end
    check("tmo_len", 32'(n), 32'd8);
    check("tmo_error", 32'(error), 32'd1);
    check("tmo_idx", 32'(seq_index), 32'd0);
    check("tmo_busy", 32'(busy), 32'd0);
    check("tmo_done", 32'(done), 32'd0);
    repeat (20) tick();
    check("tmo_enables", 32'(en_count), 32'(en0 + 1));
    check("tmo_stays_error", 32'(state), 32'(ST_ERROR));

    // Start from ERROR clears error and reruns.
    ctl_stuck = 1'b0;
    pulse_start();
    check("err_restart_clr", 32'(error), 32'd0);
    check("err_restart_state", 32'(state), 32'(ST_STARTUP));
    wait_state(ST_DONE, 100, "err_restart_done");
    check("err_restart_done_flag", 32'(done), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
